// File: rtl/riscv_lsu_if.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_lsu_if
//  Description : Request, response and memory-side signal bundle for the
//                load/store unit.
//  Revision    : 1.0
// ============================================================================
interface riscv_lsu_if #(
    parameter int XLEN = 32,
    parameter int AW   = 32,
    parameter int NB   = XLEN / 8
);
    logic            req_valid;
    logic            req_ready;
    logic            req_we;
    logic [2:0]      req_funct3;
    logic [AW-1:0]   req_addr;
    logic [XLEN-1:0] req_wdata;

    logic            resp_valid;
    logic [XLEN-1:0] resp_rdata;
    logic [1:0]      resp_err;

    logic            mem_req;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic [NB-1:0]   mem_be;
    logic [XLEN-1:0] mem_rdata;
    logic            mem_ack;

    // The LSU itself.
    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  mem_rdata, mem_ack,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );

    // The datapath and memory surrounding the LSU.
    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        output mem_rdata, mem_ack,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );
endinterface
`default_nettype wire

// File: rtl/riscv_lsu.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_lsu
//  Description : RV32I/RV64I load/store unit: lane alignment, byte enables,
//                load extension and a req/ack memory handshake.
//  Revision    : 1.0
// ============================================================================
module riscv_lsu #(
    parameter int XLEN = 32,
    parameter int AW   = 32,
    parameter int NB   = XLEN / 8,
    parameter int OB   = $clog2(NB)
) (
    input  wire logic      clk,
    input  wire logic      rst,
    riscv_lsu_if.slave     bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic            cap_we;
    logic [2:0]      cap_funct3;
    logic [AW-1:0]   cap_addr;
    logic [XLEN-1:0] cap_wdata;
    logic [XLEN-1:0] resp_rdata;
    logic [1:0]      resp_err;

    // Access size minus one, so it doubles as the low-address alignment mask.
    function automatic logic [2:0] size_m1_of(input logic [1:0] f);
        case (f)
            2'b00:   size_m1_of = 3'b000;
            2'b01:   size_m1_of = 3'b001;
            2'b10:   size_m1_of = 3'b011;
            default: size_m1_of = 3'b111;
        endcase
    endfunction

    logic [2:0] req_size_m1;
    logic       illegal;
    logic       misaligned;
    logic [1:0] err_code;

    always_comb begin
        req_size_m1 = size_m1_of(bus.req_funct3[1:0]);
        illegal     = 1'b0;
        if (bus.req_we) begin
            illegal = bus.req_funct3[2] ||
                      ((XLEN == 32) && (bus.req_funct3 == 3'b011));
        end else begin
            illegal = (bus.req_funct3 == 3'b111) ||
                      ((XLEN == 32) && ((bus.req_funct3 == 3'b011) ||
                                        (bus.req_funct3 == 3'b110)));
        end
        misaligned = |(bus.req_addr[2:0] & req_size_m1);
        err_code   = illegal ? 2'b10 : (misaligned ? 2'b01 : 2'b00);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    state_nxt = (err_code != 2'b00) ? DONE : ACCESS;
                end
            end
            ACCESS: begin
                if (bus.mem_ack) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    logic [OB-1:0]   offset;
    logic [OB+2:0]   shamt;
    logic [2:0]      cap_size_m1;
    logic [NB-1:0]   lane_mask;
    logic [XLEN-1:0] wdata_lane;
    logic [XLEN-1:0] rdata_shift;
    logic [XLEN-1:0] word_sext;
    logic [XLEN-1:0] word_zext;
    logic [XLEN-1:0] load_ext;

    assign offset      = cap_addr[OB-1:0];
    assign shamt       = {offset, 3'b000};
    assign cap_size_m1 = size_m1_of(cap_funct3[1:0]);
    assign wdata_lane  = cap_wdata << shamt;
    assign rdata_shift = bus.mem_rdata >> shamt;

    always_comb begin
        lane_mask = '0;
        for (int i = 0; i < NB; i++) begin
            lane_mask[i] = (i <= int'(cap_size_m1));
        end
    end

    // A 32-bit word is only extended when it is narrower than the register.
    generate
        if (XLEN == 64) begin : g_xlen64
            assign word_sext = {{32{rdata_shift[31]}}, rdata_shift[31:0]};
            assign word_zext = {32'b0, rdata_shift[31:0]};
        end else begin : g_xlen32
            assign word_sext = rdata_shift;
            assign word_zext = rdata_shift;
        end
    endgenerate

    always_comb begin
        load_ext = rdata_shift;
        case (cap_funct3)
            3'b000:  load_ext = {{(XLEN-8){rdata_shift[7]}},   rdata_shift[7:0]};
            3'b001:  load_ext = {{(XLEN-16){rdata_shift[15]}}, rdata_shift[15:0]};
            3'b010:  load_ext = word_sext;
            3'b100:  load_ext = {{(XLEN-8){1'b0}},  rdata_shift[7:0]};
            3'b101:  load_ext = {{(XLEN-16){1'b0}}, rdata_shift[15:0]};
            3'b110:  load_ext = word_zext;
            default: load_ext = rdata_shift;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cap_we     <= 1'b0;
            cap_funct3 <= 3'b000;
            cap_addr   <= '0;
            cap_wdata  <= '0;
            resp_rdata <= '0;
            resp_err   <= 2'b00;
        end else if ((state == IDLE) && bus.req_valid) begin
            cap_we     <= bus.req_we;
            cap_funct3 <= bus.req_funct3;
            cap_addr   <= bus.req_addr;
            cap_wdata  <= bus.req_wdata;
            resp_rdata <= '0;
            resp_err   <= err_code;
        end else if ((state == ACCESS) && bus.mem_ack && !cap_we) begin
            resp_rdata <= load_ext;
        end
    end

    logic in_access;
    assign in_access = (state == ACCESS);

    assign bus.req_ready  = (state == IDLE);
    assign bus.resp_valid = (state == DONE);
    assign bus.resp_rdata = resp_rdata;
    assign bus.resp_err   = resp_err;
    assign bus.mem_req    = in_access;
    assign bus.mem_we     = in_access & cap_we;
    assign bus.mem_addr   = in_access ? {cap_addr[AW-1:OB], {OB{1'b0}}} : '0;
    assign bus.mem_be     = in_access ? (lane_mask << offset) : '0;
    assign bus.mem_wdata  = (in_access && cap_we) ? wdata_lane : '0;

endmodule
`default_nettype wire

// File: doc/riscv_lsu.md
Name: riscv_lsu

Overview:
Parametrised load/store unit that replaces the CPU's ad-hoc load-extend register and direct memory strobes.
- Accepts one load or store request at a time from the microcoded datapath.
- Performs byte-lane alignment, write-enable byte masks, and sign/zero extension for every RV32I/RV64I width.
- Talks to memory through a req/ack handshake, so memory latency may be variable.
- Returns the result plus an error code to the datapath.

Parameters:
- XLEN, 32, data width; legal values 32 or 64. 64 enables LD/LWU/SD.
- AW, 32, address width.
- NB, XLEN/8, bytes per memory word (derived; do not override).
- OB, $clog2(NB), byte-offset bits within a word (derived).

Ports:
- clk, in, 1, rising-edge clock.
- rst, in, 1, synchronous active-high reset.
- req_valid, in, 1, request present.
- req_ready, out, 1, unit can accept a request.
- req_we, in, 1, 1 = store, 0 = load.
- req_funct3, in, 3, RISC-V funct3 of the load/store.
- req_addr, in, AW, byte address.
- req_wdata, in, XLEN, store data, right-aligned.
- resp_valid, out, 1, one-cycle completion pulse.
- resp_rdata, out, XLEN, extended load data; 0 for stores and errors.
- resp_err, out, 2, 00 ok, 01 misaligned, 10 illegal funct3.
- mem_req, out, 1, memory access request.
- mem_we, out, 1, memory write.
- mem_addr, out, AW, word-aligned address (low OB bits = 0).
- mem_wdata, out, XLEN, lane-positioned store data.
- mem_be, out, NB, byte enables.
- mem_rdata, in, XLEN, memory read word.
- mem_ack, in, 1, memory completes access this cycle.

Behaviour:
- Clock and reset: one clock domain (clk); rst is synchronous and active-high.
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=00, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_be=0.
- FSM states: IDLE, ACCESS, DONE. All outputs are registered or decoded from state and capture registers only; nothing is combinational from req_* to mem_*.
- IDLE:
  - req_ready=1.
  - On an edge with req_valid=1, capture we, funct3, addr, wdata.
  - Illegal check:
    - Loads: funct3 111 is illegal; 011 and 110 are illegal when XLEN=32.
    - Stores: funct3[2]=1 is illegal; 011 is illegal when XLEN=32.
  - Alignment: an access of size S bytes is misaligned if addr mod S != 0.
  - Error path: go to DONE with resp_err set. Illegal has priority over misaligned. No memory access is made.
  - Otherwise go to ACCESS.
- ACCESS:
  - mem_req=1, mem_we=we, mem_addr={addr[AW-1:OB], OB'b0}.
  - Stores: mem_be = size mask << addr[OB-1:0], and mem_wdata = wdata << (8*addr[OB-1:0]).
  - Loads: mem_be = the same mask, and mem_wdata=0.
  - All mem_* outputs hold stable until the edge on which mem_ack=1, then go to DONE.
  - Loads capture mem_rdata on that edge:
    - Shift right by 8*addr[OB-1:0], truncate to the size.
    - Sign-extend for LB/LH/LW(XLEN=64); zero-extend for LBU/LHU/LWU.
    - LW at XLEN=32 and LD pass through unmodified.
- DONE: resp_valid=1 for exactly one cycle, mem_req=0, req_ready=0; next state IDLE.
- resp_rdata/resp_err remain valid until the next acceptance.
- Latency, with accept on edge N:
  - mem_req is high during cycle N+1.
  - Zero-wait ack gives resp_valid in cycle N+2 and req_ready again in cycle N+3.
  - Each wait cycle adds one.
  - Error path: resp_valid in cycle N+1.
- mem_ack while not in ACCESS is ignored.
- req_valid while req_ready=0 is ignored; the requester must hold it.
- rst mid-operation: back to IDLE on that edge. The pending transaction is dropped and no resp_valid is produced; a late mem_ack is ignored.

Test Plan:
- XLEN=32, zero-wait: store SW addr 0x100 wdata 0xDEADBEEF, then LB addr 0x103 with mem_rdata 0xDEADBEEF → resp_rdata 0xFFFFFFDE, resp_err 00. LBU on the same word → 0x000000DE.
- SH addr 0x102 wdata 0x0000ABCD → mem_addr 0x100, mem_be 1100, mem_wdata 0xABCD0000, mem_we=1. LHU addr 0x102 with mem_rdata 0x80010000 → 0x00008001; LH → 0xFFFF8001.
- Misaligned and illegal:
  - LW addr 0x101 → resp_valid in cycle N+1, resp_err 01, mem_req never asserted.
  - Load funct3 011 at XLEN=32 → resp_err 10.
  - Load funct3 111 at misaligned addr 0x101 → resp_err 10 (illegal priority).
- Wait states: LW with mem_ack delayed 5 cycles → mem_addr/mem_be stable all 6 ACCESS cycles; resp_valid exactly one cycle, 7 cycles after accept; req_ready low from N+1 until cycle N+7 inclusive, high again in N+8.
- Reset mid-ACCESS: assert rst for one cycle during a wait, then pulse mem_ack → no resp_valid, all outputs at reset values, next request completes normally.
- XLEN=64:
  - LWU addr 0x104 with mem_rdata 0x80000000_00000000 → 0x00000000_80000000.
  - LW at the same address and data → 0xFFFFFFFF_80000000.
  - SD addr 0x108 → mem_be 0xFF.
